soc_ahb3_ext_sram_slave: RTL

AHB3-Lite responder that terminates one tile's external AHB3 master port (the ahb3_ext_* bundle) with a local byte-addressable SRAM.
- Decodes and accepts address phases, inserts a programmable number of wait states, and performs byte, halfword and word accesses.
- Returns the two-cycle ERROR response for illegal transfers.
- Instantiated once per tile at SoC top level, next to the MPSoC, as that tile's external memory model/target.

---
 rtl/soc_ahb3_pkg.sv | 44 ++++
 rtl/soc_ahb3_bytelane_gen.sv | 34 +++
 rtl/soc_ahb3_ext_sram_slave.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/soc_ahb3_pkg.sv
// soc_ahb3_pkg
//   Shared AHB3-Lite encodings and the responder FSM state type.
//   - HTRANS_*  : transfer type encodings
//   - HSIZE_*   : transfer size encodings (log2 of the byte count)
//   - HRESP_*   : response encodings
//   - ahb_state_e : data-phase state of the SRAM responder
//   - hsize_align_mask() : address bits below the alignment of a transfer size
package soc_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahb_state_e;

  // Low address bits that must be zero for an aligned access of this size.
  // Sizes beyond a doubleword saturate to the full 3-bit mask.
  function automatic logic [2:0] hsize_align_mask(input logic [2:0] hsize);
    logic [2:0] mask;
    case (hsize)
      HSIZE_BYTE:  mask = 3'b000;
      HSIZE_HALF:  mask = 3'b001;
      HSIZE_WORD:  mask = 3'b011;
      default:     mask = 3'b111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/soc_ahb3_bytelane_gen.sv
// soc_ahb3_bytelane_gen
//   Combinational byte-enable generator for AHB3 slaves.
//   Lane i is enabled when it lies in the same size-aligned block as the
//   addressed byte, so low address bits below the size alignment are ignored.
// Ports:
//   addr_lo  in  LANE_BITS  low address bits (byte lane of the access)
//   hsize    in  3          transfer size
//   byte_en  out XLEN/8     one enable per byte lane
module soc_ahb3_bytelane_gen
  import soc_ahb3_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int LANE_BITS = $clog2(NB)
) (
  input  logic [LANE_BITS-1:0] addr_lo,
  input  logic [2:0]           hsize,
  output logic [NB-1:0]        byte_en
);

  logic [2:0] lane;
  logic [2:0] mask;

  assign lane = 3'(addr_lo);
  assign mask = hsize_align_mask(hsize);

  always_comb begin
    byte_en = '0;
    for (int i = 0; i < NB; i++) begin
      byte_en[i] = ((3'(i) ^ lane) & ~mask) == 3'b000;
    end
  end

endmodule

// File: rtl/soc_ahb3_ext_sram_slave.sv
// soc_ahb3_ext_sram_slave
//   AHB3-Lite responder backed by a local byte-addressable SRAM. Terminates a
//   tile's external AHB3 master port. Accepts NONSEQ/SEQ address phases,
//   inserts WAIT_STATES stall cycles per transfer, performs byte/half/word
//   accesses and answers illegal transfers with the two-cycle ERROR response.
//
// Optional feature macro: AHB3_EXT_SLAVE_ALIGN_CHECK_EN
//   defined   : an address misaligned to hsize is an ERROR, nothing is written
//   undefined : low address bits below the size alignment are forced to zero
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ahb3_hsel_i         slave select
//   ahb3_haddr_i        address (PLEN)
//   ahb3_hwdata_i       write data, data phase (XLEN)
//   ahb3_hwrite_i       1 = write
//   ahb3_hsize_i        transfer size
//   ahb3_hburst_i       burst type (not used for decode)
//   ahb3_hprot_i        protection (ignored)
//   ahb3_htrans_i       IDLE/BUSY/NONSEQ/SEQ
//   ahb3_hmastlock_i    locked transfer (ignored)
//   ahb3_hrdata_o       read data, zero outside read data cycles
//   ahb3_hready_o       transfer done / bus ready
//   ahb3_hresp_o        0 = OKAY, 1 = ERROR
//
// Handshake: an address phase is taken on a rising edge where
//   ahb3_hready_o && ahb3_hsel_i && ahb3_htrans_i[1]. Its data phase ends on
//   the first later rising edge with ahb3_hready_o=1; the master holds address
//   and write data stable while ahb3_hready_o=0.
module soc_ahb3_ext_sram_slave
  import soc_ahb3_pkg::*;
#(
  parameter int              PLEN        = 32,
  parameter int              XLEN        = 32,
  parameter logic [PLEN-1:0] BASE_ADDR   = '0,
  parameter int              MEM_BYTES   = 4096,
  parameter int              WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ahb3_hsel_i,
  input  logic [PLEN-1:0] ahb3_haddr_i,
  input  logic [XLEN-1:0] ahb3_hwdata_i,
  input  logic            ahb3_hwrite_i,
  input  logic [2:0]      ahb3_hsize_i,
  input  logic [2:0]      ahb3_hburst_i,
  input  logic [3:0]      ahb3_hprot_i,
  input  logic [1:0]      ahb3_htrans_i,
  input  logic            ahb3_hmastlock_i,
  output logic [XLEN-1:0] ahb3_hrdata_o,
  output logic            ahb3_hready_o,
  output logic            ahb3_hresp_o
);

  localparam int NB        = XLEN / 8;
  localparam int LANE_BITS = $clog2(NB);
  localparam int MEM_AW    = $clog2(MEM_BYTES);
  localparam int WORDS     = MEM_BYTES / NB;

  localparam logic [PLEN-1:0] MEM_LIMIT = PLEN'(MEM_BYTES);
  localparam logic [2:0]      MAX_HSIZE = 3'(LANE_BITS);
  localparam logic [3:0]      WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // Burst, protection and lock carry no meaning for a single-master SRAM.
  logic unused_inputs;
  assign unused_inputs = ^{ahb3_hburst_i, ahb3_hprot_i, ahb3_hmastlock_i};

  // ---------------------------------------------------------------------------
  // Address phase decode
  // ---------------------------------------------------------------------------
  logic              accept;
  logic [PLEN:0]     off_full;
  logic              below_base;
  logic              above_top;
  logic              size_bad;
  logic [2:0]        lane_mask;
  logic [MEM_AW-1:0] addr_d;
  logic              err_d;

  assign accept = ahb3_hready_o & ahb3_hsel_i & ahb3_htrans_i[1];

  // One extra bit so an address below BASE_ADDR shows up as a borrow.
  assign off_full   = {1'b0, ahb3_haddr_i} - {1'b0, BASE_ADDR};
  assign below_base = off_full[PLEN];
  assign above_top  = off_full[PLEN-1:0] >= MEM_LIMIT;
  assign size_bad   = ahb3_hsize_i > MAX_HSIZE;
  assign lane_mask  = hsize_align_mask(ahb3_hsize_i);

  // Stored offset is always size-aligned; with the alignment check enabled a
  // misaligned access never reaches the data phase, so this is harmless.
  assign addr_d = off_full[MEM_AW-1:0]
                & {{(MEM_AW-LANE_BITS){1'b1}}, ~lane_mask[LANE_BITS-1:0]};

`ifdef AHB3_EXT_SLAVE_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = (3'(ahb3_haddr_i[LANE_BITS-1:0]) & lane_mask) != 3'b000;
  assign err_d      = below_base | above_top | size_bad | misaligned;
`else
  assign err_d      = below_base | above_top | size_bad;
`endif

  // ---------------------------------------------------------------------------
  // Registered address phase
  // ---------------------------------------------------------------------------
  ahb_state_e        state_q;
  ahb_state_e        state_d;
  logic [3:0]        wait_cnt_q;
  logic [3:0]        wait_cnt_d;
  logic [MEM_AW-1:0] addr_q;
  logic              write_q;
  logic [2:0]        size_q;
  logic              err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= HSIZE_BYTE;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (accept) begin
        addr_q  <= addr_d;
        write_q <= ahb3_hwrite_i;
        size_q  <= ahb3_hsize_i;
        err_q   <= err_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      // States that end with hready_o=1 may take the next address phase.
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept) begin
          if (err_d) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = ST_DATA;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs depend on state only, keeping hready_o free of input paths.
  assign ahb3_hready_o = (state_q != ST_WAIT) && (state_q != ST_ERR1);
  assign ahb3_hresp_o  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR
                                                                       : HRESP_OKAY;

  // ---------------------------------------------------------------------------
  // SRAM
  // ---------------------------------------------------------------------------
  logic [NB-1:0]            lane_en;
  logic [MEM_AW-1:0]        word_sel;
  logic [XLEN-1:0]          mem [WORDS];
  logic                     wr_en;

  soc_ahb3_bytelane_gen #(
    .XLEN (XLEN)
  ) u_bytelane (
    .addr_lo (addr_q[LANE_BITS-1:0]),
    .hsize   (size_q),
    .byte_en (lane_en)
  );

  assign word_sel = addr_q >> LANE_BITS;

  // Commit on the edge that completes the write's data phase; a reset on
  // that same edge drops the write.
  assign wr_en = (state_q == ST_DATA) && write_q && !err_q && !rst;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_en[i]) begin
          mem[word_sel[MEM_AW-LANE_BITS-1:0]][8*i +: 8] <= ahb3_hwdata_i[8*i +: 8];
        end
      end
    end
  end

  // Combinational read lets a read directly after a write see the new data.
  always_comb begin
    ahb3_hrdata_o = '0;
    if ((state_q == ST_DATA) && !write_q) begin
      ahb3_hrdata_o = mem[word_sel[MEM_AW-LANE_BITS-1:0]];
    end
  end

endmodule
